// File: rtl/pcie_cap_list_walker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pcie_cfg_pkg                                                 |
// | Description : Shared config-space constants, capability-walker state and   |
// |               error-code encodings, plus the pointer-alignment helper.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pcie_cfg_pkg;

    localparam logic [7:0] CAP_PTR_ADDR   = 8'h34;
    localparam logic [7:0] CAP_ID_MSI     = 8'h05;
    localparam logic [7:0] CAP_ID_MSIX    = 8'h11;
    localparam logic [7:0] CAP_MIN_OFFSET = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_PTR = 2'd1,
        ST_RD_HDR = 2'd2,
        ST_DONE   = 2'd3
    } walk_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_BAD_PTR   = 2'b01,
        ERR_HOP_LIMIT = 2'b10,
        ERR_ACK_TMO   = 2'b11
    } cap_err_t;

    // Capability pointers are dword aligned; the low two bits are reserved.
    function automatic logic [7:0] cap_ptr_align(input logic [7:0] ptr);
        return ptr & 8'hFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cap_list_walker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pcie_cap_list_walker_if                                      |
// | Description : Config-space read port. master = walker, slave = register   |
// |               file. req/addr held until a 1-cycle ack carrying data.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pcie_cap_list_walker_if;
    logic        cfg_rd_req;
    logic [7:0]  cfg_rd_addr;
    logic        cfg_rd_ack;
    logic [31:0] cfg_rd_data;

    modport master (
        output cfg_rd_req,
        output cfg_rd_addr,
        input  cfg_rd_ack,
        input  cfg_rd_data
    );

    modport slave (
        input  cfg_rd_req,
        input  cfg_rd_addr,
        output cfg_rd_ack,
        output cfg_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/pcie_cap_list_walker_cfg_rd_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cfg_rd_timeout_counter                                       |
// | Description : Counts cycles an outstanding read has gone unacknowledged.   |
// |   clk, reset : clock, async active-high reset                              |
// |   i_clear    : restart the count (a new request is being issued)           |
// |   i_en       : request outstanding and not acked this cycle                |
// |   o_expire   : this is the LIMIT-th unacked cycle of the request           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cfg_rd_timeout_counter #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_clear,
    input  wire  i_en,
    output logic o_expire
);
    localparam logic [W-1:0] c_LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] c_ONE  = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_expire = i_en && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/pcie_cap_list_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcie_cap_list_walker                                         |
// | Description : Walks the PCI capability linked list from the Capabilities   |
// |               Pointer (0x34) to find a capability ID; reports its offset   |
// |               and full header dword.                                       |
// |   clk, reset          : clock, async active-high reset                     |
// |   i_start             : 1-cycle walk request, ignored while not idle       |
// |   i_start_id_sel/_id  : 0 = search TARGET_ID_DEFAULT, 1 = search i_start_id |
// |   cfg                 : config read port (master side)                     |
// |   o_busy / o_done     : walk in progress / 1-cycle completion pulse        |
// |   o_found, o_cap_*    : match result, held until next accepted start       |
// |   o_error, o_err_code : 01 bad pointer, 10 hop limit, 11 ack timeout       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcie_cap_list_walker
    import pcie_cfg_pkg::*;
#(
    parameter logic [7:0] TARGET_ID_DEFAULT = CAP_ID_MSIX,
    parameter int          MAX_HOPS         = 48,
    parameter int          TIMEOUT_CYCLES   = 64,
    parameter int          TMO_W            = 7
) (
    input  wire                      clk,
    input  wire                      reset,
    input  wire                      i_start,
    input  wire                      i_start_id_sel,
    input  wire [7:0]                i_start_id,
    pcie_cap_list_walker_if.master   cfg,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_found,
    output logic [7:0]               o_cap_offset,
    output logic [31:0]              o_cap_hdr,
    output logic                     o_error,
    output logic [1:0]               o_err_code
);
    localparam logic [7:0] c_MAX_HOPS = 8'(MAX_HOPS);

    walk_state_t r_state;
    cap_err_t    r_err_code;
    logic [7:0]  r_tgt_id;
    logic [7:0]  r_hop;
    logic        r_req;
    logic [7:0]  r_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic        r_error;
    logic [7:0]  r_cap_offset;
    logic [31:0] r_cap_hdr;

    logic        w_ack;
    logic        w_issue;
    logic        w_tmo_en;
    logic        w_tmo_expire;
    logic [7:0]  w_ptr;
    logic [7:0]  w_next;
    logic [7:0]  w_hop_inc;

    // An ack only counts while a request is actually outstanding.
    assign w_ack     = cfg.cfg_rd_ack & r_req;
    assign w_ptr     = cap_ptr_align(cfg.cfg_rd_data[7:0]);
    assign w_next    = cap_ptr_align(cfg.cfg_rd_data[15:8]);
    assign w_hop_inc = r_hop + 8'd1;

    // Header reads are issued from RD_HDR while req is low, which guarantees
    // one idle cycle after the previous ack.
    assign w_issue  = ((r_state == ST_IDLE) && i_start) ||
                      ((r_state == ST_RD_HDR) && !r_req);
    assign w_tmo_en = r_req & ~cfg.cfg_rd_ack;

    cfg_rd_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TMO_W)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_issue),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_err_code   <= ERR_NONE;
            r_tgt_id     <= 8'h00;
            r_hop        <= 8'h00;
            r_req        <= 1'b0;
            r_addr       <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_error      <= 1'b0;
            r_cap_offset <= 8'h00;
            r_cap_hdr    <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_tgt_id     <= i_start_id_sel ? i_start_id : TARGET_ID_DEFAULT;
                        r_found      <= 1'b0;
                        r_error      <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_cap_offset <= 8'h00;
                        r_cap_hdr    <= 32'h0;
                        r_hop        <= 8'h00;
                        r_req        <= 1'b1;
                        r_addr       <= CAP_PTR_ADDR;
                        r_busy       <= 1'b1;
                        r_state      <= ST_RD_PTR;
                    end
                end

                ST_RD_PTR: begin
                    if (w_ack) begin
                        r_req <= 1'b0;
                        if (w_ptr == 8'h00) begin
                            r_busy <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else if (w_ptr < CAP_MIN_OFFSET) begin
                            r_error <= 1'b1; r_err_code <= ERR_BAD_PTR;
                            r_busy  <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else begin
                            r_addr  <= w_ptr;
                            r_state <= ST_RD_HDR;
                        end
                    end else if (w_tmo_expire) begin
                        r_req   <= 1'b0;
                        r_error <= 1'b1; r_err_code <= ERR_ACK_TMO;
                        r_busy  <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                    end
                end

                ST_RD_HDR: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (w_ack) begin
                        r_req <= 1'b0;
                        r_hop <= w_hop_inc;
                        // Match wins over every termination condition below.
                        if (cfg.cfg_rd_data[7:0] == r_tgt_id) begin
                            r_found      <= 1'b1;
                            r_cap_offset <= r_addr;
                            r_cap_hdr    <= cfg.cfg_rd_data;
                            r_busy <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else if (w_next == 8'h00) begin
                            r_busy <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else if (w_next < CAP_MIN_OFFSET) begin
                            r_error <= 1'b1; r_err_code <= ERR_BAD_PTR;
                            r_busy  <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else if (w_hop_inc == c_MAX_HOPS) begin
                            r_error <= 1'b1; r_err_code <= ERR_HOP_LIMIT;
                            r_busy  <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                        end else begin
                            r_addr <= w_next;
                        end
                    end else if (w_tmo_expire) begin
                        r_req   <= 1'b0;
                        r_error <= 1'b1; r_err_code <= ERR_ACK_TMO;
                        r_busy  <= 1'b0; r_done <= 1'b1; r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_rd_req  = r_req;
    assign cfg.cfg_rd_addr = r_addr;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_found         = r_found;
    assign o_cap_offset    = r_cap_offset;
    assign o_cap_hdr       = r_cap_hdr;
    assign o_error         = r_error;
    assign o_err_code      = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_pcie_cap_list_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pcie_cap_list_walker                                      |
// | Description : Self-checking bench: config-space memory slave with random   |
// |               ack delays, list-walk reference model, per-cycle monitor.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pcie_cap_list_walker;
    localparam int MAX_HOPS = 48;
    localparam int TMO      = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_id_sel = 1'b0;
    logic [7:0]  start_id = 8'h00;
    logic        busy, done, found, error;
    logic [7:0]  cap_offset;
    logic [31:0] cap_hdr;
    logic [1:0]  err_code;

    pcie_cap_list_walker_if bus();

    pcie_cap_list_walker dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (start),
        .i_start_id_sel (start_id_sel),
        .i_start_id     (start_id),
        .cfg            (bus.master),
        .o_busy         (busy),
        .o_done         (done),
        .o_found        (found),
        .o_cap_offset   (cap_offset),
        .o_cap_hdr      (cap_hdr),
        .o_error        (error),
        .o_err_code     (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [31:0] mem [64];
    int  withhold = -1;
    int  dmin = 0, dmax = 10;
    bit  stray = 0;
    int  wait_cnt = -1;

    initial begin
        bus.cfg_rd_ack  = 1'b0;
        bus.cfg_rd_data = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (bus.cfg_rd_ack) begin
                bus.cfg_rd_ack = 1'b0;
                wait_cnt = -1;
            end else if (stray) begin
                bus.cfg_rd_ack  = 1'b1;
                bus.cfg_rd_data = 32'h0000_0011;
                stray = 0;
            end else if (!bus.cfg_rd_req || reset) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt < 0)
                    wait_cnt = (withhold >= 0 && bus.cfg_rd_addr == withhold[7:0]) ? 1000000
                             : int'($urandom_range(dmin, dmax));
                if (wait_cnt == 0) begin
                    bus.cfg_rd_ack  = 1'b1;
                    bus.cfg_rd_data = mem[bus.cfg_rd_addr[7:2]];
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_reads[$];
    logic        exp_found;
    logic [7:0]  exp_off;
    logic [31:0] exp_hdr;
    logic [1:0]  exp_err;

    function automatic void model_walk(input logic [7:0] tgt, input int wh);
        logic [7:0]  p, n;
        logic [31:0] d;
        int hops = 0;
        exp_reads.delete();
        exp_found = 0; exp_off = 0; exp_hdr = 0; exp_err = 0;
        exp_reads.push_back(8'h34);
        if (wh == 'h34) begin exp_err = 3; return; end
        d = mem[13];
        p = d[7:0] & 8'hFC;
        if (p == 0) return;
        if (p < 8'h40) begin exp_err = 1; return; end
        forever begin
            exp_reads.push_back(p);
            if (wh >= 0 && p == wh[7:0]) begin exp_err = 3; return; end
            d = mem[p[7:2]];
            hops++;
            if (d[7:0] == tgt) begin exp_found = 1; exp_off = p; exp_hdr = d; return; end
            n = d[15:8] & 8'hFC;
            if (n == 0) return;
            if (n < 8'h40) begin exp_err = 1; return; end
            if (hops == MAX_HOPS) begin exp_err = 2; return; end
            p = n;
        end
    endfunction

    // ---------------- per-cycle monitor ----------------
    bit         active = 0, done_seen = 0;
    int         issue_idx = 0, run_len = 0;
    logic       prev_req = 0, prev_ack = 0, prev_done = 0;
    logic [7:0] prev_addr = 0;

    always @(negedge clk) begin
        if (reset) begin
            issue_idx = 0; run_len = 0;
            prev_req = 0; prev_ack = 0; prev_done = 0;
        end else begin
            if (bus.cfg_rd_req) begin
                chk("busy_with_req", busy, 1);
                if (!prev_req) begin
                    if (issue_idx < exp_reads.size())
                        chk("rd_addr", bus.cfg_rd_addr, exp_reads[issue_idx]);
                    else
                        chk("extra_read", issue_idx, exp_reads.size());
                    issue_idx++;
                    run_len = 1;
                end else begin
                    run_len++;
                    chk("addr_stable", bus.cfg_rd_addr, prev_addr);
                end
            end
            if (prev_req && prev_ack) chk("req_drop_after_ack", bus.cfg_rd_req, 0);
            if (done) begin
                chk("done_expected", active, 1);
                chk("done_one_cycle", prev_done, 0);
                chk("busy_at_done", busy, 0);
                chk("read_count", issue_idx, exp_reads.size());
                chk("found", found, exp_found);
                chk("cap_offset", cap_offset, exp_off);
                chk("cap_hdr", cap_hdr, exp_hdr);
                chk("err_code", err_code, exp_err);
                chk("error", error, (exp_err != 0));
                chk("req_low_at_done", bus.cfg_rd_req, 0);
                if (exp_err == 3) chk("tmo_req_cycles", run_len, TMO);
                else              chk("done_after_ack", prev_req & prev_ack, 1);
                done_seen = 1;
                issue_idx = 0;
            end
            prev_req  = bus.cfg_rd_req;
            prev_ack  = bus.cfg_rd_ack;
            prev_addr = bus.cfg_rd_addr;
            prev_done = done;
        end
    end

    // ---------------- driver ----------------
    task automatic do_start(input bit sel, input logic [7:0] id);
        @(posedge clk); #2;
        start = 1; start_id_sel = sel; start_id = id;
        @(posedge clk); #2;
        start = 0;
    endtask

    task automatic run_walk(input bit sel, input logic [7:0] id, input int wh);
        withhold = wh;
        model_walk(sel ? id : 8'h11, wh);
        done_seen = 0;
        active = 1;
        do_start(sel, id);
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_req", bus.cfg_rd_req, 1);
        chk("start_addr", bus.cfg_rd_addr, 8'h34);
        for (int i = 0; i < 5000 && !done_seen; i++) @(negedge clk);
        if (!done_seen) chk("done_within_bound", done_seen, 1);
        @(negedge clk);
        active = 0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8'h34 >> 2] = 32'h0000_0050;
        mem[8'h50 >> 2] = {16'h0000, 8'h70, 8'h05};
        mem[8'h70 >> 2] = {16'h8007, 8'h00, 8'h11};
    endtask

    logic [7:0] ids [6] = '{8'h01, 8'h05, 8'h09, 8'h10, 8'h11, 8'h12};

    initial begin
        logic [7:0]  offs [6];
        logic [31:0] w;
        logic [7:0]  nxt;
        int k, idx;
        bit used;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_found", found, 0); chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0); chk("rst_cap_offset", cap_offset, 0);
        chk("rst_cap_hdr", cap_hdr, 0);   chk("rst_req", bus.cfg_rd_req, 0);
        @(posedge clk); #2 reset = 0;

        // Basic chain, default MSI-X target
        load_basic();
        run_walk(0, 8'h00, -1);
        chk("model_t1_reads", exp_reads.size(), 3);
        chk("t1_found", found, 1);
        chk("t1_offset", cap_offset, 8'h70);
        chk("t1_hdr", cap_hdr, 32'h8007_0011);

        // Alternate target absent from the chain
        run_walk(1, 8'h10, -1);
        chk("t2_found", found, 0);
        chk("t2_offset", cap_offset, 8'h00);

        // Null capability pointer, then misaligned low pointer
        mem[13] = 32'h0;
        run_walk(0, 8'h00, -1);
        chk("t3_error", error, 0);
        mem[13] = 32'h0000_0023;
        run_walk(0, 8'h00, -1);
        chk("t4_err_code", err_code, 2'b01);

        // Two-entry loop with no match
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[13]         = 32'h0000_0040;
        mem[8'h40 >> 2] = {16'h0, 8'h44, 8'h01};
        mem[8'h44 >> 2] = {16'h0, 8'h40, 8'h02};
        dmin = 0; dmax = 1;
        run_walk(0, 8'h00, -1);
        chk("model_loop_reads", exp_reads.size(), 1 + MAX_HOPS);
        chk("t5_err_code", err_code, 2'b10);
        dmin = 0; dmax = 10;

        // Ack withheld on the 0x50 read, then a stray late ack, then restart
        load_basic();
        run_walk(0, 8'h00, 'h50);
        chk("t6_err_code", err_code, 2'b11);
        withhold = -1;
        stray = 1;
        repeat (5) begin
            @(negedge clk);
            chk("late_ack_no_busy", busy, 0);
            chk("late_ack_no_done", done, 0);
        end
        chk("late_ack_err_held", err_code, 2'b11);
        run_walk(0, 8'h00, -1);
        chk("t6_restart_found", found, 1);

        // Reset while waiting on the 0x70 read
        withhold = 'h70;
        model_walk(8'h11, 'h70);
        active = 1;
        do_start(0, 8'h00);
        for (int i = 0; i < 500 && !(bus.cfg_rd_req && bus.cfg_rd_addr == 8'h70); i++) @(negedge clk);
        chk("reached_0x70", bus.cfg_rd_addr, 8'h70);
        #2 reset = 1;
        #1;
        chk("async_rst_req", bus.cfg_rd_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(posedge clk); #2 start = 1;
        @(posedge clk); #2 reset = 0; start = 0;
        @(negedge clk);
        chk("start_at_rst_release_ignored", busy, 0);
        active = 0;
        withhold = -1;
        run_walk(0, 8'h00, -1);
        chk("after_rst_found", found, 1);

        // Randomised chains
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 64; i++) begin w = $urandom; mem[i] = w; end
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                do begin
                    idx = $urandom_range(16, 63);
                    used = 0;
                    for (int m = 0; m < j; m++) if (offs[m] == 8'(idx * 4)) used = 1;
                end while (used);
                offs[j] = 8'(idx * 4);
            end
            w = $urandom;
            mem[13] = {w[31:8], offs[0] | 8'($urandom_range(0, 3))};
            if (it % 7 == 6) mem[13] = {w[31:8], 8'h10 | 8'($urandom_range(0, 3))};
            for (int j = 0; j < k; j++) begin
                if (j < k - 1)            nxt = offs[j + 1];
                else if (it % 5 == 4)     nxt = offs[0];
                else if (it % 4 == 3)     nxt = 8'h20;
                else                      nxt = 8'h00;
                nxt = nxt | 8'($urandom_range(0, 3));
                w = $urandom;
                mem[offs[j][7:2]] = {w[31:16], nxt, ids[$urandom_range(0, 5)]};
            end
            run_walk(1'($urandom_range(0, 1)), ids[$urandom_range(0, 5)], -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire

// File: doc/pcie_cap_list_walker.md
Name: pcie_cap_list_walker

Overview:
Config-space reader that walks the PCI capability linked list to locate a capability by ID (default MSI-X, 0x11). Starts at the Capabilities Pointer (byte 0x34) and follows each header's Next Capability Pointer (bits 15:8) until a match, a terminating null pointer, or an error. Sits between the config-space register file (read port) and MSI-X/MSI setup logic. Reports the match offset and full header dword, including Message Control.

Parameters:
TARGET_ID_DEFAULT, 8'h11, capability ID searched when start_id_sel=0
MAX_HOPS, 48, maximum headers visited before loop error; (256-64)/4
TIMEOUT_CYCLES, 64, cycles to wait for cfg_rd_ack before timeout error
TMO_W, 7, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock
reset  input  1  async active-high reset
start  input  1  1-cycle pulse; begins a walk; ignored while busy
start_id_sel  input  1  0: use TARGET_ID_DEFAULT; 1: use start_id
start_id  input  8  alternate target ID, sampled with start
cfg_rd_req  output  1  config read request; held until ack
cfg_rd_addr  output  8  dword-aligned byte address; addr[1:0]=0
cfg_rd_ack  input  1  1-cycle; cfg_rd_data valid this cycle
cfg_rd_data  input  32  read dword
busy  output  1  walk in progress
done  output  1  1-cycle pulse at end of walk
found  output  1  valid with done; held until next start
cap_offset  output  8  byte offset of matched header; 0 if not found
cap_hdr  output  32  matched header dword; bits 7:0=ID, 15:8=next, 31:16=msg ctrl
error  output  1  valid with done; held until next start
err_code  output  2  00 none, 01 pointer <0x40, 10 hop limit, 11 ack timeout

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, counters 0; an in-flight request is dropped, and any later ack is ignored.
- States: IDLE, RD_PTR, RD_HDR, DONE.
- IDLE: on start, latch the target ID, clear found/error/err_code/cap_offset/cap_hdr, set hop=0, go to RD_PTR. The next cycle sets cfg_rd_req=1, cfg_rd_addr=0x34, busy=1.
- Handshake: req and addr are stable until the ack cycle. req drops the cycle after ack. The next request issues no earlier than the cycle after that (one idle cycle between requests). Ack without req is ignored.
- RD_PTR ack: ptr = data[7:0] & 8'hFC.
  - ptr==0: DONE, not found, no error.
  - ptr<0x40: DONE, err 01.
  - Otherwise: RD_HDR at addr ptr.
- RD_HDR ack: hop++.
  - data[7:0]==target: found=1, cap_offset=current addr, cap_hdr=data, DONE.
  - Otherwise next = data[15:8] & 8'hFC.
  - next==0: DONE, not found.
  - next<0x40: err 01.
  - hop==MAX_HOPS: err 10. The match check takes priority over the hop limit on the same ack.
  - Else read next.
- Timeout: the counter resets on each new request. If TIMEOUT_CYCLES elapse with no ack, drop req and go to DONE with err 11.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. found/error/cap_* hold until the next accepted start.
- start during busy or DONE is ignored. A start in the same cycle as a reset deassertion edge is ignored.
- Latency: 0x34 read then N header reads; done is asserted the cycle after the final ack.

Decomposition:
- Shared package pcie_cfg_pkg:
  - CAP_PTR_ADDR=8'h34, CAP_ID_MSI=8'h05, CAP_ID_MSIX=8'h11, CAP_MIN_OFFSET=8'h40
  - walker state enum
  - err_code enum
- Sub-module cfg_rd_timeout_counter (load/clear, expire flag) for the ack timeout. The rest stays flat.

Test Plan:
- Memory model with 0x34=0x50; 0x50 = {16'h0000, next 0x70, ID 0x05}; 0x70 = {16'h8007, next 0x00, ID 0x11}; start -> 3 reads (0x34, 0x50, 0x70), found=1, cap_offset=0x70, cap_hdr=0x80070011, error=0, done pulses once.
- Same chain with start_id_sel=1, start_id=0x10 -> reaches 0x70 with next=0, found=0, error=0, cap_offset=0.
- 0x34 reads 0x00 -> a single read, done with found=0, error=0. 0x34 reads 0x23 -> masked to 0x20, err_code=01.
- Loop 0x40 -> 0x44 -> 0x40 with no match -> done after 48 header reads, err_code=10.
- Ack withheld for the 0x50 read -> req drops after 64 cycles, err_code=11. A late ack is ignored, and a new start works.
- Reset asserted while waiting on the 0x70 read -> req, busy and done are 0 immediately. A start after reset restarts at 0x34. Randomised ack delays of 0-10 cycles keep addr stable under req.
